// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one registered bitwise logic unit between two requesters
module logic_unit_arbiter #(
    parameter int size = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic [size-1:0] req0_a,
    input  logic [size-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic [size-1:0] req1_a,
    input  logic [size-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [size-1:0] rsp_data,
    output logic            rsp_zero,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
    state_e          state_q;
    logic            last_q, owner_q, busy_q, rsp0_valid_q, rsp1_valid_q;
    logic [1:0]      op_q;
    logic [size-1:0] a_q, b_q, rsp_data_q, rsp_data_d;
    logic            gnt0, gnt1;
    // On contention the requester not served last wins
    assign gnt0 = !rst && state_q == IDLE && req0_valid && (!req1_valid || last_q);
    assign gnt1 = !rst && state_q == IDLE && req1_valid && (!req0_valid || !last_q);
    assign rsp_data_d = op_q == 2'b00 ? a_q & b_q :
                        op_q == 2'b01 ? a_q | b_q :
                        op_q == 2'b10 ? a_q ^ b_q : ~(a_q & b_q);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            rsp_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt0 || gnt1) begin
                    op_q    <= gnt1 ? req1_op : req0_op;
                    a_q     <= gnt1 ? req1_a : req0_a;
                    b_q     <= gnt1 ? req1_b : req0_b;
                    owner_q <= gnt1;
                    last_q  <= gnt1;
                    busy_q  <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: begin
                    rsp_data_q   <= rsp_data_d;
                    rsp0_valid_q <= !owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= RESP;
                end
                RESP: if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_zero   = rsp_data_q == '0;
    assign busy       = busy_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed vector table plus hand-written multi-cycle sequences
module tb_logic_unit_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic [1:0]  req0_op = 0, req1_op = 0;
    logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, busy;
    logic [15:0] rsp_data;
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        logic        who;
        logic [1:0]  op;
        logic [15:0] a, b, exp;
    } vec_t;
    vec_t vecs[7];

    logic_unit_arbiter #(.size(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {28'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int  g;
        logic gl[4];
        vecs[0] = '{1'b0, 2'b00, 16'h00F8, 16'h0147, 16'h0040};
        vecs[1] = '{1'b1, 2'b01, 16'h00F8, 16'h0147, 16'h01FF};
        vecs[2] = '{1'b1, 2'b10, 16'h00F8, 16'h0147, 16'h01BF};
        vecs[3] = '{1'b1, 2'b11, 16'h00F8, 16'h0147, 16'hFFBF};
        vecs[4] = '{1'b1, 2'b00, 16'hFF00, 16'h00FF, 16'h0000};
        vecs[5] = '{1'b0, 2'b01, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[6] = '{1'b0, 2'b10, 16'hA5A5, 16'hA5A5, 16'h0000};

        tick();
        tick();
        chk_quiet("reset_outputs");
        chk("reset_data", {16'd0, rsp_data}, 32'd0);
        chk("reset_zero", {31'd0, rsp_zero}, 32'd1);
        rst = 0;
        tick();

        for (int i = 0; i < 7; i++) begin
            req0_valid = !vecs[i].who; req1_valid = vecs[i].who;
            req0_op = vecs[i].op; req1_op = vecs[i].op;
            req0_a = vecs[i].a; req1_a = vecs[i].a; req0_b = vecs[i].b; req1_b = vecs[i].b;
            rsp0_ready = 1; rsp1_ready = 1;
            #1;
            chk("vec_ready", {30'd0, req1_ready, req0_ready}, vecs[i].who ? 32'd2 : 32'd1);
            tick();
            req0_valid = 0; req1_valid = 0;
            chk("vec_exec", {29'd0, busy, rsp1_valid, rsp0_valid}, 32'd4);
            tick();
            chk("vec_rsp_valid", {29'd0, busy, rsp1_valid, rsp0_valid}, vecs[i].who ? 32'd6 : 32'd5);
            chk("vec_data", {16'd0, rsp_data}, {16'd0, vecs[i].exp});
            chk("vec_zero", {31'd0, rsp_zero}, {31'd0, vecs[i].exp == 16'd0});
            tick();
            chk_quiet("vec_idle");
        end

        // contention after reset: 0,1,0,1
        rst = 1;
        tick();
        rst = 0;
        req0_valid = 1; req0_op = 2'b00; req0_a = 16'hFFFF; req0_b = 16'h1234;
        req1_valid = 1; req1_op = 2'b01; req1_a = 16'h0000; req1_b = 16'h5678;
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        g = 0;
        for (int c = 0; c < 30 && g < 4; c++) begin
            if (req0_ready || req1_ready) begin
                chk("grant_excl", {31'd0, req0_ready && req1_ready}, 32'd0);
                gl[g] = req1_ready;
                g++;
            end
            if (rsp0_valid) chk("rr_rsp0_data", {16'd0, rsp_data}, 32'h1234);
            if (rsp1_valid) chk("rr_rsp1_data", {16'd0, rsp_data}, 32'h5678);
            if ((rsp0_valid || rsp1_valid) && g > 0) chk("rr_owner", {31'd0, rsp1_valid}, {31'd0, gl[g-1]});
            chk("rsp_excl", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        req0_valid = 0; req1_valid = 0;
        chk("grant_count", g, 32'd4);
        for (int i = 0; i < 4 && i < g; i++) chk("grant_order", {31'd0, gl[i]}, i % 2);
        tick();
        chk("rr_last_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
        chk("rr_last_data", {16'd0, rsp_data}, 32'h5678);
        tick();
        chk_quiet("rr_idle");

        // response stall with requester 1 waiting
        req0_valid = 1; req0_op = 2'b00; req0_a = 16'h00F8; req0_b = 16'h0147;
        req1_valid = 1; req1_op = 2'b10; req1_a = 16'hF0F0; req1_b = 16'h0FF0;
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        chk("stall_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_hold", {28'd0, busy, req1_ready, rsp1_valid, rsp0_valid}, 32'h9);
            chk("stall_data", {16'd0, rsp_data}, 32'h0040);
            tick();
        end
        rsp0_ready = 1;
        #1;
        chk("stall_release_resp", {30'd0, req1_ready, rsp0_valid}, 32'd1);
        tick();
        rsp0_ready = 0;
        chk("stall_next_grant", {29'd0, busy, req1_ready, req0_ready}, 32'd2);
        tick();
        req1_valid = 0; rsp1_ready = 1;
        tick();
        chk("stall_r1_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
        chk("stall_r1_data", {16'd0, rsp_data}, 32'hFF00);
        tick();
        chk_quiet("stall_idle");

        // reset during EXEC
        req0_valid = 1; req0_op = 2'b01; req0_a = 16'h1111; req0_b = 16'h2222;
        rsp0_ready = 0; rsp1_ready = 0;
        tick();
        req0_valid = 0;
        chk("rstx_in_exec", {31'd0, busy}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        chk_quiet("rstx_after");
        tick();
        chk_quiet("rstx_no_rsp");
        // reset during RESP
        req0_valid = 1;
        tick();
        req0_valid = 0;
        tick();
        chk("rstr_in_resp", {30'd0, busy, rsp0_valid}, 32'd3);
        rst = 1;
        tick();
        rst = 0;
        chk_quiet("rstr_after");
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_contention", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        tick();
        chk("rst_contention_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
        tick();

        // operands captured at grant
        req0_valid = 1; req0_op = 2'b00; req0_a = 16'h0F0F; req0_b = 16'h00FF;
        tick();
        req0_valid = 0; req0_a = 16'hFFFF; req0_b = 16'hFFFF;
        tick();
        chk("capture_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("capture_data", {16'd0, rsp_data}, 32'h000F);
        tick();
        chk_quiet("capture_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
